axis_decimator: RTL
===================

# axis_decimator

Integer-factor AXI-Stream decimator placed directly downstream of `fir_filter`; the FIR output stream is its only input. It keeps one of every `DECIM` accepted input samples and requantises the kept sample from `IN_WIDTH` to `OUT_WIDTH` with round-half-up and saturation. A two-entry output buffer gives full throughput with registered `tready`. A sticky flag reports saturation events.

## Interface
- `IN_WIDTH`, default 16: input sample width, signed two's complement; must match the FIR `DATA_WIDTH`.
- `OUT_WIDTH`, default 12: output sample width, signed; 1 ≤ `OUT_WIDTH` ≤ `IN_WIDTH`.
- `DECIM`, default 4: decimation factor, ≥ 1; 1 means pass-through with requantisation.
- `clk_i`, input, 1 bit: single clock; everything is on the rising edge.
- `arst_i`, input, 1 bit: asynchronous, active-high reset.
- `s_axis`, `axis_if.slave`, `tdata` is `IN_WIDTH` bits: input sample stream from `fir_filter.m_axis`.
- `m_axis`, `axis_if.master`, `tdata` is `OUT_WIDTH` bits: decimated, requantised output stream.
- `clr_i`, input, 1 bit: synchronous clear of `phase` and `sat_o`; does not flush buffered output.
- `sat_o`, output, 1 bit: sticky flag, set when any kept sample saturated.

## Operation
- **Shift.** S = `IN_WIDTH` − `OUT_WIDTH`.
- **Input handshake.** An input beat is accepted when `s_axis.tvalid & s_axis.tready`.
- **Phase counter.** `phase` counts 0..`DECIM`−1 and advances only on accepted beats. It wraps from `DECIM`−1 to 0.
- **Kept sample.** The beat accepted while `phase` == 0 is kept. All other accepted beats are discarded.
- **Requantise (S > 0).**
  - Sign-extend `tdata` to `IN_WIDTH`+1 bits.
  - Add 2^(S−1), then arithmetic-shift right by S.
  - If the result is > 2^(`OUT_WIDTH`−1)−1, clamp to that maximum. If it is < −2^(`OUT_WIDTH`−1), clamp to that minimum.
  - Any clamp sets `sat_o`.
- **Requantise (S == 0).** The sample passes unchanged and `sat_o` never sets.
- **Output buffer.** Two entries: `out` (drives `m_axis`) and `skid`.
  - `s_axis.tready` is registered and equals `~skid_valid` for the next cycle.
  - Discarded beats need no storage, but they still follow `tready`.
- **Buffer update per cycle.** Let k = kept beat accepted, h = `m_axis.tvalid & m_axis.tready`.
  - `out` empty, k: the sample goes to `out`.
  - `out` full, no skid, h and k: the sample goes to `out`.
  - `out` full, no skid, k without h: the sample goes to `skid`.
  - Skid full, h: `skid` moves to `out`; an incoming k cannot occur because `tready` = 0.
  - h without k and without skid: `out` empties.
- **Ordering.** Output order always equals input order.
- **`clr_i`.**
  - Sets `phase` to 0 and `sat_o` to 0.
  - If `clr_i` and an accepted beat occur in the same cycle, that beat is treated as phase 0 (kept).
  - If that kept beat saturates, `sat_o` ends the cycle at 1.

## Timing
- **Reset values (`arst_i` high, asynchronous):**
  - `m_axis.tvalid` = 0, `m_axis.tdata` = 0, `s_axis.tready` = 0.
  - `sat_o` = 0, `phase` = 0, both buffer entries empty.
- **After reset release.** `s_axis.tready` rises on the first clock edge after `arst_i` falls.
- **Latency.** A kept sample accepted at edge N appears on `m_axis` (`tvalid` = 1) after edge N, i.e. one cycle latency.
- **Saturation flag.** `sat_o` rises on the same edge that loads the saturated sample.
- **Throughput.** With `m_axis.tready` held at 1, `s_axis.tready` stays 1 continuously. Output rate is exactly one beat per `DECIM` accepted inputs.
- **Stability.** `m_axis.tdata` must not change while `tvalid & ~tready`.
- **Mid-operation reset.** Reset clears buffered samples and phase immediately. The first accepted beat after reset is kept.

## Test plan
- **Decimate, no saturation.** Reset; IN 16 / OUT 12 / `DECIM` 4; `m_axis.tready` = 1. Drive 0x0018, 0x1234, 0x1234, 0x1234, 0xFFF7.
  - Outputs: 0x002, then 0xFFF.
  - Output beats arrive 4 inputs apart; `sat_o` stays 0.
- **Saturation and clear.**
  - Kept input 0x7FF8 gives 0x7FF and `sat_o` = 1.
  - Kept input 0x8000 gives 0x800; `sat_o` stays 1 (sticky).
  - Pulse `clr_i`: `sat_o` = 0 and the next accepted beat is kept.
- **Backpressure.** `DECIM` = 1, inputs 1..6 << 4; hold `m_axis.tready` = 0.
  - Exactly 2 beats are accepted, then `s_axis.tready` = 0.
  - Release `tready`: outputs 1..6 in order, none lost or duplicated.
- **Random stress.** Random `s_axis.tvalid` / `m_axis.tready` at 50% for 10 000 inputs, `DECIM` = 3.
  - The scoreboard matches every 3rd input, requantised.
  - `tdata` is stable under stall.
- **Mid-stream reset.** Assert `arst_i` with both buffer entries full.
  - Outputs drop to reset values asynchronously.
  - After release, the first accepted input is emitted.
- **Pass-through.** IN = OUT = 16, `DECIM` = 1.
  - Output equals input bit-exact, latency 1; `sat_o` never sets.

Source files
------------

// File: rtl/axis_decimator_if.sv
// AXI-Stream handshake bundle (valid/ready/data) shared by the decimator's
// input and output streams; WIDTH sets the tdata width per instance.
interface axis_if #(
  parameter int WIDTH = 16
) ();
  logic             tvalid;
  logic             tready;
  logic [WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_decimator.sv
// Integer-factor AXI-Stream decimator: keeps one of every DECIM accepted beats,
// requantises it with round-half-up and saturation, and buffers it in out/skid.
module axis_decimator #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 12,
  parameter int DECIM     = 4
) (
  input  logic   clk_i,
  input  logic   arst_i,
  axis_if.slave  s_axis,
  axis_if.master m_axis,
  input  logic   clr_i,
  output logic   sat_o
);

  localparam int SHIFT = IN_WIDTH - OUT_WIDTH;
  localparam int PW    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(DECIM - 1);

  logic [PW-1:0]        phase_q, phase_d, phase_base;
  logic                 sat_q, sat_d;
  logic                 tready_q, tready_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [OUT_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                 accept, keep, hand;
  logic [OUT_WIDTH-1:0] rq_data;
  logic                 rq_sat;

  generate
    if (SHIFT == 0) begin : g_pass
      assign rq_data = s_axis.tdata;
      assign rq_sat  = 1'b0;
    end else begin : g_round
      localparam logic [IN_WIDTH:0]    HALF  = (IN_WIDTH + 1)'(1) << (SHIFT - 1);
      localparam logic [OUT_WIDTH-1:0] MIN_V = OUT_WIDTH'(1) << (OUT_WIDTH - 1);

      logic [IN_WIDTH:0]  sum;
      logic [OUT_WIDTH:0] shr;
      logic               unused_frac;

      // One guard bit above the output width exposes overflow as a sign mismatch.
      always_comb begin
        sum    = {s_axis.tdata[IN_WIDTH-1], s_axis.tdata} + HALF;
        shr    = sum[IN_WIDTH:SHIFT];
        rq_sat = shr[OUT_WIDTH] ^ shr[OUT_WIDTH-1];
        if (!rq_sat) begin
          rq_data = shr[OUT_WIDTH-1:0];
        end else if (shr[OUT_WIDTH]) begin
          rq_data = MIN_V;
        end else begin
          rq_data = ~MIN_V;
        end
      end

      assign unused_frac = ^sum[SHIFT-1:0];
    end
  endgenerate

  always_comb begin
    accept     = s_axis.tvalid & tready_q;
    keep       = accept & (clr_i | (phase_q == '0));
    hand       = out_valid_q & m_axis.tready;

    phase_base = clr_i ? '0 : phase_q;
    phase_d    = phase_base;
    if (accept) begin
      phase_d = (phase_base == LAST_PHASE) ? '0 : phase_base + 1'b1;
    end

    sat_d = (sat_q & ~clr_i) | (keep & rq_sat);
  end

  // A kept beat can only arrive while skid is empty, since tready tracks ~skid_valid.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (skid_valid_q) begin
      if (hand) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (!out_valid_q || hand) begin
      out_valid_d = keep;
      if (keep) begin
        out_data_d = rq_data;
      end
    end else if (keep) begin
      skid_valid_d = 1'b1;
      skid_data_d  = rq_data;
    end

    tready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      phase_q      <= '0;
      sat_q        <= 1'b0;
      tready_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      phase_q      <= phase_d;
      sat_q        <= sat_d;
      tready_q     <= tready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign s_axis.tready = tready_q;
  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tdata  = out_data_q;
  assign sat_o         = sat_q;

endmodule
